state_hex_display: RTL and testbench
====================================

# state_hex_display

Parametrised successor to the one-hot-state-to-seven-segment decoder. Takes the one-hot state vector of a control FSM and drives NUM_DIGITS seven-segment digits from a per-state message table, with registered outputs, illegal-state detection, and static/blink/scroll/blank display modes timed by an internal tick prescaler. Sits between any one-hot FSM and the board HEX outputs.

## Interface

- NUM_STATES, default 7: width of the one-hot state input.
- NUM_DIGITS, default 6: digits driven; digit 0 = rightmost (HEX0).
- TICK_DIV, default 25_000_000: clocks per display tick (blink/scroll period); ≥2.
- MSG_TABLE, default '0: packed NUM_STATES*NUM_DIGITS*4 bits; nibble for state s, digit d at bits [(s*NUM_DIGITS+d)*4 +: 4].

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- state  in  NUM_STATES  one-hot FSM state.
- mode  in  2  00 static, 01 blink, 10 scroll, 11 blank.
- hex_out  out  7*NUM_DIGITS  active-low segments; digit d at [d*7 +: 7], bit0=a … bit6=g.
- illegal  out  1  state input not one-hot.

## Operation

- Input stage: state and mode registered every cycle into state_q, mode_q; `primed` flag set the cycle after reset deasserts, gating all outputs until it is set.
- Legality: state_q legal iff exactly one bit set. Zero bits or multiple bits are illegal.
- Legal: index s = position of set bit; digit d nibble = MSG_TABLE entry (s,d), decoded 0–F by sev_seg.
- Illegal: illegal=1, every digit shows dash 7'b0111111, regardless of mode (except blank). Clears the cycle after the state returns to one-hot.
- Tick prescaler: tick_cnt counts 0..TICK_DIV-1, wraps to 0; one-cycle `tick` pulse on wrap.
- Static (00): decoded digits shown continuously.
- Blink (01): phase bit toggles on each tick; phase=0 shows digits, phase=1 forces all 7'h7F.
- Scroll (10): offset counts 0..NUM_DIGITS-1 on each tick, wraps to 0; digit i shows message digit (i+offset) mod NUM_DIGITS (rotate left).
- Blank (11): all digits 7'h7F, illegal still reported.
- Restart: change of state_q or mode_q clears tick_cnt, phase, and offset in the same cycle; the display restarts visible at offset 0.

## Timing

- Reset values: hex_out all 1s (blank), illegal=0, state_q=0, mode_q=0, tick_cnt=0, phase=0, offset=0, primed=0.
- Latency: input change → hex_out/illegal update 2 clocks later (input register, output register).
- First valid output: 2 clocks after reset deasserts. hex_out stays blank until then.
- Tick: first tick TICK_DIV cycles after a restart. Blink half-period and scroll step = TICK_DIV clocks.
- Simultaneous restart and tick: restart wins; counters clear, no toggle or offset advance.
- Reset mid-blink/scroll: all counters clear immediately; output blank on the next edge.

## Structure

- Package state_hex_pkg: mode enum (MODE_STATIC, MODE_BLINK, MODE_SCROLL, MODE_BLANK), SEG_BLANK=7'h7F, SEG_DASH=7'b0111111.
- Sub-module: sev_seg, a combinational nibble→active-low segment decoder, instantiated NUM_DIGITS times.
- One-hot legality check and index encoding as a function in the package.

## Test plan

Bench uses TICK_DIV=4, defaults otherwise, MSG_TABLE state0="000000", state3="111111".

- Reset, then state=7'b0000001, mode=00 → hex_out blank for 2 clocks, then every digit 7'b1000000; illegal=0.
- state=7'b0001000, mode=00 → 2 clocks later every digit 7'b1111001.
- state=7'b0000000, then 7'b0001001 → illegal=1, all digits 7'b0111111; back to 7'b0000001 → illegal=0 within 2 clocks.
- mode=01 → digits visible 4 clocks, blank 7'h7F 4 clocks, repeating. A state change mid-blank restarts visible immediately after the 2-clock latency.
- mode=10 with distinct nibbles per digit → digit 0 shows message digits 0,1,…,5,0 at 4-clock steps. Offset wraps 5→0.
- Assert reset during scroll at offset 3 → next edge hex_out blank, offset 0; after release the display restarts at offset 0.

Source files
------------

// File: rtl/state_hex_pkg.sv
// state_hex_pkg: display modes, segment constants and one-hot helpers
package state_hex_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_SCROLL = 2'b10,
        MODE_BLANK  = 2'b11
    } mode_e;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'b0111111;
    localparam int         MAX_STATES = 64;

    function automatic logic onehot_legal(input logic [MAX_STATES-1:0] v);
        int cnt = 0;
        for (int i = 0; i < MAX_STATES; i++) cnt = cnt + int'(v[i]);
        return cnt == 1;
    endfunction

    function automatic int onehot_index(input logic [MAX_STATES-1:0] v);
        int idx = 0;
        for (int i = 0; i < MAX_STATES; i++) if (v[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/sev_seg.sv
// sev_seg: hex nibble to active-low seven-segment pattern (bit0=a .. bit6=g)
module sev_seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // lookup of the sixteen hex glyphs
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/state_hex_display.sv
// state_hex_display: one-hot FSM state to multi-digit seven-segment message with blink/scroll
module state_hex_display
    import state_hex_pkg::*;
#(
    parameter int NUM_STATES = 7,
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 25_000_000,
    parameter logic [NUM_STATES*NUM_DIGITS*4-1:0] MSG_TABLE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_STATES-1:0]   state,
    input  logic [1:0]              mode,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    illegal
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int OW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = NUM_STATES > 1 ? $clog2(NUM_STATES) : 1;
    localparam int HW = 7 * NUM_DIGITS;

    logic [NUM_STATES-1:0] state_q;
    mode_e                 mode_q;
    logic                  primed;
    logic [TW-1:0]         tick_cnt;
    logic                  phase;
    logic [OW-1:0]         offset;
    logic                  restart;
    logic                  tick;
    logic                  legal;
    logic [SW-1:0]         sel;
    logic [3:0]            msg [NUM_STATES][NUM_DIGITS];
    logic [HW-1:0]         seg_flat;
    logic [HW-1:0]         rot;
    logic [HW-1:0]         next_hex;

    assign restart = (state != state_q) || (mode_e'(mode) != mode_q);
    assign tick    = tick_cnt == TW'(TICK_DIV - 1);
    assign legal   = onehot_legal(MAX_STATES'(state_q));
    assign sel     = SW'(onehot_index(MAX_STATES'(state_q)));

    for (genvar s = 0; s < NUM_STATES; s++) begin : g_msg
        for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
            assign msg[s][d] = MSG_TABLE[(s*NUM_DIGITS+d)*4 +: 4];
        end
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_seg
        sev_seg u_seg (
            .nibble (msg[sel][d]),
            .seg    (seg_flat[d*7 +: 7])
        );
    end

    // input stage: register state/mode; primed marks the first post-reset sample
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            mode_q  <= MODE_STATIC;
            primed  <= 1'b0;
        end else begin
            state_q <= state;
            mode_q  <= mode_e'(mode);
            primed  <= 1'b1;
        end
    end

    // tick prescaler, blink phase and scroll offset; a restart beats a coincident tick
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            tick_cnt <= '0;
            phase    <= 1'b0;
            offset   <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            phase    <= ~phase;
            offset   <= offset == OW'(NUM_DIGITS - 1) ? '0 : offset + 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // rotate left by offset digits: digit i shows message digit (i+offset) mod NUM_DIGITS
    always_comb begin
        rot = HW'({seg_flat, seg_flat} >> (7 * offset));
    end

    assign next_hex = mode_q == MODE_BLANK              ? {NUM_DIGITS{SEG_BLANK}} :
                      !legal                            ? {NUM_DIGITS{SEG_DASH}}  :
                      (mode_q == MODE_BLINK && phase)   ? {NUM_DIGITS{SEG_BLANK}} :
                      mode_q == MODE_SCROLL             ? rot                     :
                                                          seg_flat;

    // output register, held blank until the input stage has a valid sample
    always_ff @(posedge clk) begin
        if (reset || !primed) begin
            hex_out <= '1;
            illegal <= 1'b0;
        end else begin
            hex_out <= next_hex;
            illegal <= !legal;
        end
    end

endmodule

// File: tb/tb_state_hex_display.sv
// tb_state_hex_display: randomized scoreboard bench against an age-based behavioural model
module tb_state_hex_display;

    localparam int NS = 7;
    localparam int ND = 6;
    localparam int TD = 4;

    function automatic logic [3:0] nib(input int s, input int d);
        if (s == 0) return 4'h0;
        if (s == 3) return 4'h1;
        return 4'((s * 3 + d * 5 + 1) % 16);
    endfunction

    function automatic logic [NS*ND*4-1:0] build_msg();
        logic [NS*ND*4-1:0] m = '0;
        for (int s = 0; s < NS; s++)
            for (int d = 0; d < ND; d++)
                m[(s*ND+d)*4 +: 4] = nib(s, d);
        return m;
    endfunction

    localparam logic [NS*ND*4-1:0] MSG = build_msg();
    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic            clk;
    logic            reset;
    logic [NS-1:0]   state;
    logic [1:0]      mode;
    logic [7*ND-1:0] hex_out;
    logic            illegal;

    state_hex_display #(
        .NUM_STATES (NS),
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD),
        .MSG_TABLE  (MSG)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .state   (state),
        .mode    (mode),
        .hex_out (hex_out),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7*ND-1:0] hex;
        logic            ill;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    logic [NS-1:0] m_sq = '0;
    logic [1:0]    m_mq = '0;
    int            m_age = 0;
    bit            m_primed = 0;

    // expected output after the coming edge, from the registered inputs and cycles since restart
    function automatic exp_t model_out();
        exp_t e;
        int idx = 0;
        int ticks, ph, off;
        logic [6:0] g;
        e.hex = {ND{7'h7F}};
        e.ill = 1'b0;
        if (!m_primed) return e;
        for (int i = 0; i < NS; i++) if (m_sq[i]) idx = i;
        e.ill = $countones(m_sq) != 1;
        ticks = m_age / TD;
        ph = ticks % 2;
        off = ticks % ND;
        if (m_mq == 2'd3) return e;
        for (int d = 0; d < ND; d++) begin
            if (e.ill) g = 7'b0111111;
            else if (m_mq == 2'd1 && ph == 1) g = 7'h7F;
            else if (m_mq == 2'd2) g = SEG_TAB[nib(idx, (d + off) % ND)];
            else g = SEG_TAB[nib(idx, d)];
            e.hex[d*7 +: 7] = g;
        end
        return e;
    endfunction

    task automatic step(input logic [NS-1:0] s, input logic [1:0] m, input logic r);
        exp_t e;
        state = s;
        mode  = m;
        reset = r;
        if (r) begin
            e.hex = {ND{7'h7F}};
            e.ill = 1'b0;
        end else begin
            e = model_out();
        end
        sb.push_back(e);
        if (r) begin
            m_sq = '0;
            m_mq = '0;
            m_age = 0;
            m_primed = 0;
        end else begin
            m_age = (s != m_sq || m != m_mq) ? 0 : m_age + 1;
            m_sq = s;
            m_mq = m;
            m_primed = 1;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [NS-1:0] s, input logic [1:0] m, input int n);
        repeat (n) step(s, m, 1'b0);
    endtask

    // monitor: one expected response per clock, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (hex_out !== e.hex) begin
                    failures++;
                    $display("FAIL hex_out t=%0t got=%h exp=%h", $time, hex_out, e.hex);
                end
                checks++;
                if (illegal !== e.ill) begin
                    failures++;
                    $display("FAIL illegal t=%0t got=%b exp=%b", $time, illegal, e.ill);
                end
            end
        end
    end

    initial begin
        logic [NS-1:0] s;
        logic [1:0] m;
        step('0, 2'd0, 1'b1);
        step('0, 2'd0, 1'b1);
        hold(7'b0000001, 2'd0, 6);
        hold(7'b0001000, 2'd0, 5);
        hold(7'b0000000, 2'd0, 4);
        hold(7'b0001001, 2'd0, 4);
        hold(7'b0000001, 2'd0, 4);
        hold(7'b0000100, 2'd1, 22);
        hold(7'b0010000, 2'd1, 12);
        hold(7'b0000010, 2'd2, 30);
        hold(7'b0000010, 2'd0, 1);
        hold(7'b0000010, 2'd2, 14);
        step(7'b0000010, 2'd2, 1'b1);
        hold(7'b0000010, 2'd2, 12);
        hold(7'b0110000, 2'd3, 4);
        hold(7'b0110000, 2'd1, 10);
        hold(7'b1000000, 2'd3, 4);
        for (int k = 0; k < 40; k++) begin
            int kind = int'($urandom_range(0, 9));
            s = 7'(1 << $urandom_range(0, NS - 1));
            m = 2'($urandom_range(0, 3));
            if (kind == 0) begin
                repeat ($urandom_range(1, 2)) step(s, m, 1'b1);
            end else begin
                if (kind <= 2) s = 7'($urandom);
                hold(s, m, int'($urandom_range(1, 30)));
            end
        end
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
